// File: rtl/dmem_responder_pkg.sv
// Shared types for the data-memory responder.
//   dmem_state_t : responder FSM states
//   dmem_req_t   : latched copy of one dmem request (word address, masks, data)
package rv32i_types;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } dmem_state_t;

    typedef struct packed {
        logic [31:2] addr;
        logic [3:0]  rmask;
        logic [3:0]  wmask;
        logic [31:0] wdata;
    } dmem_req_t;

endpackage

// File: rtl/dmem_responder_if.sv
// dmem request/response bundle between the memory stage (master) and a responder (slave).
//   addr, rmask, wmask, wdata : request, driven by the master
//   rdata, resp, err          : completion, driven by the slave
interface dmem_responder_if;
    logic [31:0] addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        resp;
    logic        err;

    modport master (
        output addr, rmask, wmask, wdata,
        input  rdata, resp, err
    );

    modport slave (
        input  addr, rmask, wmask, wdata,
        output rdata, resp, err
    );
endinterface

// File: rtl/dmem_word_array.sv
// Word-organised storage with one synchronous read port and one byte-masked
// synchronous write port sharing a single address. Contents are not reset.
//   clk   : clock
//   addr  : word index
//   we    : write enable; wmask selects byte lanes, wdata is lane-aligned
//   re    : read enable; rdata holds the word read on the last enabled edge
module dmem_word_array #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned IDX_W       = 10
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] addr,
    input  logic             we,
    input  logic [3:0]       wmask,
    input  logic [31:0]      wdata,
    input  logic             re,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        if (re) begin
            rdata_q <= mem[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one dmem request, waits LATENCY cycles and
// returns a one-cycle completion pulse. Reads return the full word; writes
// are byte-lane masked; out-of-range or read+write requests complete with err.
//   clk, rst_n : clock, asynchronous active-low reset
//   dmem       : slave side of the dmem request/response bundle
module dmem_responder
    import rv32i_types::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    dmem_responder_if.slave   dmem
);

    localparam int unsigned CNT_W = $clog2(LATENCY + 1);
    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    dmem_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    dmem_req_t        req_q, req_d;
    logic             err_q, err_d;
    logic             rd_ok_q, rd_ok_d;

    dmem_req_t   req_live, cur_req;
    logic        req_present, commit;
    logic [31:0] byte_addr, idx_full;
    logic        bad, we, re;
    logic [31:0] arr_rdata;
    logic        unused_addr_lsb;

    assign unused_addr_lsb = ^dmem.addr[1:0];

    assign req_live = '{addr: dmem.addr[31:2], rmask: dmem.rmask,
                        wmask: dmem.wmask, wdata: dmem.wdata};
    assign req_present = |(dmem.rmask | dmem.wmask);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        commit  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_present) begin
                    req_d = req_live;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // With LATENCY=1 the commit edge is also the accept edge, so the latched
    // copy is not yet available and the live request is used instead.
    assign cur_req   = (state_q == IDLE) ? req_live : req_q;
    assign byte_addr = {cur_req.addr, 2'b00};
    assign idx_full  = (byte_addr - BASE_ADDR) >> 2;
    assign bad       = (byte_addr < BASE_ADDR)
                     || (idx_full >= 32'(DEPTH_WORDS))
                     || ((|cur_req.rmask) && (|cur_req.wmask));

    assign we      = commit && !bad && (|cur_req.wmask);
    assign re      = commit && !bad && !(|cur_req.wmask);
    assign err_d   = commit && bad;
    assign rd_ok_d = re;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            err_q   <= 1'b0;
            rd_ok_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            err_q   <= err_d;
            rd_ok_q <= rd_ok_d;
        end
    end

    dmem_word_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk   (clk),
        .addr  (idx_full[IDX_W-1:0]),
        .we    (we),
        .wmask (cur_req.wmask),
        .wdata (cur_req.wdata),
        .re    (re),
        .rdata (arr_rdata)
    );

    // err_q and rd_ok_q are only ever set for the single RESP cycle.
    assign dmem.resp  = (state_q == RESP);
    assign dmem.err   = err_q;
    assign dmem.rdata = rd_ok_q ? arr_rdata : 32'h0;

endmodule
